// File: rtl/traffic_sensor_if.sv
// -----------------------------------------------------------------------------
// traffic_sensor_if
//
// Sensor front end for the two-street traffic light controller. Each street
// has its own identical channel. A channel synchronizes the raw vehicle sensor
// and debounces it. It then latches a waiting request until the street has
// seen a full uninterrupted green, and keeps a saturating vehicle count.
//
// Optional feature (macro TRAFFIC_STUCK_DET_EN):
//   When defined, each channel flags a sensor that stays high for STUCK_CYCLES
//   synchronized cycles. The flag is sticky. While it is set, the channel
//   masks vehicle detection and parks its request FSM in IDLE, so a dead
//   sensor cannot hold the intersection. When undefined, the fault outputs
//   are constant 0.
//
// Parameters:
//   DEBOUNCE     consecutive synchronized-high cycles that register a vehicle
//   SERVE_CYCLES consecutive green cycles that clear a pending request
//   CNT_W        width of each vehicle counter
//   STUCK_CYCLES high-run length flagged as a stuck sensor (feature only)
//
// Ports (top):
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   sensor_main   in   raw asynchronous main-street sensor
//   sensor_first  in   raw asynchronous first-street sensor
//   green_main    in   main-street green lamp (synchronous)
//   green_first   in   first-street green lamp (synchronous)
//   clr_counts    in   synchronous clear of counters and fault flags
//   waiting_main  out  latched main-street request
//   waiting_first out  latched first-street request
//   count_main    out  main-street vehicle count, saturating
//   count_first   out  first-street vehicle count, saturating
//   fault_main    out  main sensor stuck
//   fault_first   out  first sensor stuck
// -----------------------------------------------------------------------------

module traffic_sensor_chan #(
    parameter int DEBOUNCE     = 3,
    parameter int SERVE_CYCLES = 4,
    parameter int CNT_W        = 8,
    parameter int STUCK_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sensor_i,
    input  logic             green_i,
    input  logic             clr_i,
    output logic             waiting_o,
    output logic [CNT_W-1:0] count_o,
    output logic             fault_o
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int SW = $clog2(SERVE_CYCLES + 1);
    localparam logic [DW-1:0]    DEB_MAX  = DW'(DEBOUNCE);
    localparam logic [DW-1:0]    DEB_HIT  = DW'(DEBOUNCE - 1);
    localparam logic [SW-1:0]    SRV_LAST = SW'(SERVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SERVING = 2'd2
    } state_e;

    logic [1:0]       sync_q;
    logic             s;
    logic [DW-1:0]    deb_q, deb_d;
    logic             det_raw;
    logic             det;
    state_e           state_q, state_d;
    logic [SW-1:0]    serve_q, serve_d;
    logic             waiting_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_q, fault_d;

    // Two-flop synchronizer for the raw sensor line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sensor_i};
        end
    end

    assign s = sync_q[1];

    // Debounce counter: counts the current high run and saturates
    always_comb begin
        deb_d = deb_q;
        if (!s) begin
            deb_d = {DW{1'b0}};
        end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + DW'(1);
        end else begin
            deb_d = deb_q;
        end
    end

    // One detection per high run, on the cycle the run reaches DEBOUNCE
    assign det_raw = s && (deb_q == DEB_HIT);

`ifdef TRAFFIC_STUCK_DET_EN
    localparam int TW = $clog2(STUCK_CYCLES + 1);
    localparam logic [TW-1:0] STUCK_MAX = TW'(STUCK_CYCLES);

    logic [TW-1:0] stuck_q, stuck_d;

    // Stuck run counter and sticky fault; clr_counts restarts both
    always_comb begin
        stuck_d = stuck_q;
        fault_d = fault_q;
        if (clr_i) begin
            stuck_d = {TW{1'b0}};
            fault_d = 1'b0;
        end else begin
            if (!s) begin
                stuck_d = {TW{1'b0}};
            end else if (stuck_q != STUCK_MAX) begin
                stuck_d = stuck_q + TW'(1);
            end else begin
                stuck_d = stuck_q;
            end
            fault_d = fault_q | (stuck_d == STUCK_MAX);
        end
    end

    // Stuck run counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stuck_q <= {TW{1'b0}};
        end else begin
            stuck_q <= stuck_d;
        end
    end
`else
    // Stuck detection compiled out: fault never raised
    always_comb begin
        fault_d = 1'b0;
    end
`endif

    // A faulted sensor is ignored from the very edge the fault is raised
    assign det = det_raw & ~fault_d;

    // Request FSM next state; serve_q counts consecutive green cycles
    always_comb begin
        state_d = state_q;
        serve_d = serve_q;
        if (fault_d) begin
            state_d = ST_IDLE;
            serve_d = {SW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    serve_d = {SW{1'b0}};
                    // A car arriving on green drives through: count only
                    if (det && !green_i) begin
                        state_d = ST_PENDING;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    if (green_i) begin
                        if (SERVE_CYCLES == 1) begin
                            state_d = ST_IDLE;
                            serve_d = {SW{1'b0}};
                        end else begin
                            state_d = ST_SERVING;
                            serve_d = SW'(1);
                        end
                    end else begin
                        state_d = ST_PENDING;
                        serve_d = {SW{1'b0}};
                    end
                end
                ST_SERVING: begin
                    // Completion wins over a same-cycle detection
                    if (green_i) begin
                        if (serve_q == SRV_LAST) begin
                            state_d = ST_IDLE;
                            serve_d = {SW{1'b0}};
                        end else begin
                            state_d = ST_SERVING;
                            serve_d = serve_q + SW'(1);
                        end
                    end else begin
                        state_d = ST_PENDING;
                        serve_d = {SW{1'b0}};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    serve_d = {SW{1'b0}};
                end
            endcase
        end
    end

    // Saturating vehicle counter; clear beats increment
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (det && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_q     <= {DW{1'b0}};
            state_q   <= ST_IDLE;
            serve_q   <= {SW{1'b0}};
            waiting_q <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
            fault_q   <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            state_q   <= state_d;
            serve_q   <= serve_d;
            waiting_q <= (state_d != ST_IDLE);
            count_q   <= count_d;
            fault_q   <= fault_d;
        end
    end

    assign waiting_o = waiting_q;
    assign count_o   = count_q;
    assign fault_o   = fault_q;

endmodule

module traffic_sensor_if #(
    parameter int DEBOUNCE     = 3,
    parameter int SERVE_CYCLES = 4,
    parameter int CNT_W        = 8,
    parameter int STUCK_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_main,
    input  logic             sensor_first,
    input  logic             green_main,
    input  logic             green_first,
    input  logic             clr_counts,
    output logic             waiting_main,
    output logic             waiting_first,
    output logic [CNT_W-1:0] count_main,
    output logic [CNT_W-1:0] count_first,
    output logic             fault_main,
    output logic             fault_first
);

    traffic_sensor_chan #(
        .DEBOUNCE     (DEBOUNCE),
        .SERVE_CYCLES (SERVE_CYCLES),
        .CNT_W        (CNT_W),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_main (
        .clk_i     (clk),
        .rst_i     (rst),
        .sensor_i  (sensor_main),
        .green_i   (green_main),
        .clr_i     (clr_counts),
        .waiting_o (waiting_main),
        .count_o   (count_main),
        .fault_o   (fault_main)
    );

    traffic_sensor_chan #(
        .DEBOUNCE     (DEBOUNCE),
        .SERVE_CYCLES (SERVE_CYCLES),
        .CNT_W        (CNT_W),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_first (
        .clk_i     (clk),
        .rst_i     (rst),
        .sensor_i  (sensor_first),
        .green_i   (green_first),
        .clr_i     (clr_counts),
        .waiting_o (waiting_first),
        .count_o   (count_first),
        .fault_o   (fault_first)
    );

endmodule

// File: tb/tb_traffic_sensor_if.sv
// -----------------------------------------------------------------------------
// tb_traffic_sensor_if
//
// Directed bench for traffic_sensor_if. A behavioural model describes each
// street in plain terms:
//   - the sensor as seen two clocks late;
//   - the length of the current high run;
//   - whether a request is outstanding and how many green cycles it has had;
//   - the vehicle tally.
// A compare process checks every DUT output against the model on each falling
// edge. Literal expectations are also checked at the key points of the
// scenario.
// Build with +define+TRAFFIC_STUCK_DET_EN to exercise the stuck-sensor path.
// -----------------------------------------------------------------------------

module tb_traffic_sensor_if;

    localparam int DEBOUNCE     = 3;
    localparam int SERVE_CYCLES = 4;
    localparam int CNT_W        = 8;
    localparam int STUCK_CYCLES = 64;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic clk          = 1'b0;
    logic rst          = 1'b1;
    logic sensor_main  = 1'b0;
    logic sensor_first = 1'b0;
    logic green_main   = 1'b0;
    logic green_first  = 1'b0;
    logic clr_counts   = 1'b0;
    logic             waiting_main, waiting_first, fault_main, fault_first;
    logic [CNT_W-1:0] count_main, count_first;

    int checks = 0;
    int passed = 0;

    // Model state, index 0 = main street, 1 = first street
    bit m_p0[2];
    bit m_p1[2];
    int m_run[2];
    int m_srun[2];
    int m_cnt[2];
    int m_sc[2];
    bit m_wait[2];
    bit m_fault[2];

    traffic_sensor_if #(
        .DEBOUNCE     (DEBOUNCE),
        .SERVE_CYCLES (SERVE_CYCLES),
        .CNT_W        (CNT_W),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sensor_main   (sensor_main),
        .sensor_first  (sensor_first),
        .green_main    (green_main),
        .green_first   (green_first),
        .clr_counts    (clr_counts),
        .waiting_main  (waiting_main),
        .waiting_first (waiting_first),
        .count_main    (count_main),
        .count_first   (count_first),
        .fault_main    (fault_main),
        .fault_first   (fault_first)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_p0[c] = 1'b0;  m_p1[c] = 1'b0;
            m_run[c] = 0;    m_srun[c] = 0;
            m_cnt[c] = 0;    m_sc[c] = 0;
            m_wait[c] = 1'b0; m_fault[c] = 1'b0;
        end
    endtask

    // One clock of one street, using the inputs present before the edge
    task automatic model_step(input int ch, input bit sens, input bit grn);
        bit s;
        bit det;
        s        = m_p1[ch];
        m_p1[ch] = m_p0[ch];
        m_p0[ch] = sens;
        m_run[ch] = s ? m_run[ch] + 1 : 0;
        det = s && (m_run[ch] == DEBOUNCE);
`ifdef TRAFFIC_STUCK_DET_EN
        m_srun[ch]  = (clr_counts || !s) ? 0 : m_srun[ch] + 1;
        m_fault[ch] = !clr_counts && (m_fault[ch] || (m_srun[ch] >= STUCK_CYCLES));
        if (m_fault[ch]) det = 1'b0;
`endif
        if (clr_counts) m_cnt[ch] = 0;
        else if (det && (m_cnt[ch] < CNT_MAX)) m_cnt[ch] = m_cnt[ch] + 1;
        if (m_fault[ch]) begin
            m_wait[ch] = 1'b0;
            m_sc[ch]   = 0;
        end else if (m_wait[ch]) begin
            if (grn) begin
                m_sc[ch] = m_sc[ch] + 1;
                if (m_sc[ch] == SERVE_CYCLES) begin
                    m_wait[ch] = 1'b0;
                    m_sc[ch]   = 0;
                end
            end else begin
                m_sc[ch] = 0;
            end
        end else if (det && !grn) begin
            m_wait[ch] = 1'b1;
        end
    endtask

    // Model advance
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_step(0, sensor_main, green_main);
                model_step(1, sensor_first, green_first);
            end
        end
    end

    // Cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            check("cmp waiting_main",  waiting_main,  m_wait[0]);
            check("cmp waiting_first", waiting_first, m_wait[1]);
            check("cmp count_main",    count_main,    m_cnt[0]);
            check("cmp count_first",   count_first,   m_cnt[1]);
            check("cmp fault_main",    fault_main,    m_fault[0]);
            check("cmp fault_first",   fault_first,   m_fault[1]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Directed scenario
    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset waiting_main", waiting_main, 0);
        check("reset count_main", count_main, 0);
        rst = 1'b0;

        // Main-street car on red: request appears after edge DEBOUNCE+2
        sensor_main = 1'b1;
        step(4);
        check("latency edge4 waiting_main", waiting_main, 0);
        step(1);
        check("latency edge5 waiting_main", waiting_main, 1);
        check("latency count_main", count_main, 1);
        step(5);
        sensor_main = 1'b0;
        check("one det per run count_main", count_main, 1);
        check("quiet waiting_first", waiting_first, 0);

        // Two-cycle glitch on first street is not a car
        sensor_first = 1'b1;
        step(2);
        sensor_first = 1'b0;
        step(6);
        check("glitch count_first", count_first, 0);
        check("glitch waiting_first", waiting_first, 0);

        // Full green clears the request on the 4th green edge
        green_main = 1'b1;
        step(3);
        check("serve 3 waiting_main", waiting_main, 1);
        step(1);
        check("serve 4 waiting_main", waiting_main, 0);
        green_main = 1'b0;

        // New request, then an interrupted green
        sensor_main = 1'b1;
        step(5);
        sensor_main = 1'b0;
        check("rerequest waiting_main", waiting_main, 1);
        check("rerequest count_main", count_main, 2);
        green_main = 1'b1;
        step(2);
        green_main = 1'b0;
        step(1);
        check("interrupted waiting_main", waiting_main, 1);
        green_main = 1'b1;
        step(3);
        check("rerun 3 waiting_main", waiting_main, 1);
        step(1);
        check("rerun 4 waiting_main", waiting_main, 0);

        // Cars on green pass through but are counted
        sensor_main = 1'b1;
        step(5);
        sensor_main = 1'b0;
        step(3);
        check("green pass count_main", count_main, 3);
        check("green pass waiting_main", waiting_main, 0);
        for (int i = 0; i < 4; i++) begin
            sensor_main = 1'b1;
            step(4);
            sensor_main = 1'b0;
            step(3);
        end
        check("seven count_main", count_main, 7);

        // Clear coincides with a detection on red
        green_main  = 1'b0;
        sensor_main = 1'b1;
        step(4);
        clr_counts = 1'b1;
        step(1);
        clr_counts  = 1'b0;
        sensor_main = 1'b0;
        check("clr vs det count_main", count_main, 0);
        check("clr vs det waiting_main", waiting_main, 1);

        // Saturation
        green_main = 1'b1;
        for (int i = 0; i < CNT_MAX + 3; i++) begin
            sensor_main = 1'b1;
            step(4);
            sensor_main = 1'b0;
            step(3);
        end
        check("saturate count_main", count_main, CNT_MAX);
        check("saturate waiting_main", waiting_main, 0);
        green_main = 1'b0;

        // First-street sensor stuck high
        sensor_first = 1'b1;
        step(70);
        check("stuck count_first", count_first, 1);
        check("stuck fault_main", fault_main, 0);
`ifdef TRAFFIC_STUCK_DET_EN
        check("stuck fault_first", fault_first, 1);
        check("stuck waiting_first", waiting_first, 0);
`else
        check("stuck fault_first", fault_first, 0);
        check("stuck waiting_first", waiting_first, 1);
`endif
        sensor_first = 1'b0;
        step(3);
        clr_counts = 1'b1;
        step(1);
        clr_counts = 1'b0;
        check("after clr fault_first", fault_first, 0);
        check("after clr count_first", count_first, 0);
`ifdef TRAFFIC_STUCK_DET_EN
        check("after clr waiting_first", waiting_first, 0);
`else
        check("after clr waiting_first", waiting_first, 1);
`endif

        // Reset mid-request; a held sensor must re-debounce from scratch
        sensor_main = 1'b1;
        step(6);
        check("pre-reset waiting_main", waiting_main, 1);
        rst = 1'b1;
        #1;
        check("async reset waiting_main", waiting_main, 0);
        check("async reset count_main", count_main, 0);
        step(1);
        rst = 1'b0;
        step(4);
        check("re-debounce edge4 waiting_main", waiting_main, 0);
        step(1);
        check("re-debounce edge5 waiting_main", waiting_main, 1);
        check("re-debounce count_main", count_main, 1);
        sensor_main = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
